// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared FSM state encoding and default bus widths for apb_master
package apb_master_pkg;

  localparam int APB_DEFAULT_WORD       = 16;
  localparam int APB_DEFAULT_ADDR_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// rtl/apb_wait_counter.sv - counts ACCESS cycles spent waiting for PREADY
module apb_wait_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // clear wins over enable so a fresh transfer always starts from zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding request-to-APB bridge with wait timeout
module apb_master
  import apb_master_pkg::*;
#(
  parameter int AMBA_WORD       = APB_DEFAULT_WORD,
  parameter int AMBA_ADDR_WIDTH = APB_DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] req_addr,
  input  logic [AMBA_WORD-1:0]       req_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY
);

  apb_state_t state;
  logic       accept;
  logic       wait_expired;

  assign accept = (state == IDLE) && req_valid && req_ready;

  apb_wait_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  ((state == ACCESS) && !PREADY),
    .expired (wait_expired)
  );

  // PADDR/PWDATA/PWRITE double as the request latch and hold across IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            PWRITE    <= req_write;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a response on the limit cycle still succeeds
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (wait_expired) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed and randomized self-checking bench for apb_master
module tb_apb_master;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(
    .AMBA_WORD       (DW),
    .AMBA_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural view: a transfer spends min(waits+1, TO) cycles in ACCESS and
  // succeeds only when PREADY arrives within the first TO access cycles.
  task automatic do_transfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int waits, input logic [DW-1:0] rd);
    int  n_access;
    bit  ok;
    logic [DW-1:0] exp_rd;
    ok       = (waits < TO);
    n_access = ok ? waits + 1 : TO;
    exp_rd   = (ok && !wr) ? rd : '0;

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; PREADY = 1'b0;
    check({tag, " ready_idle"}, {63'd0, req_ready}, 64'd1);
    cycle();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = $urandom;
    check({tag, " setup"}, {PSEL, PENABLE, rsp_valid, req_ready, PWRITE, PADDR, PWDATA},
          {1'b1, 1'b0, 1'b0, 1'b0, wr, addr, wdata});
    for (int k = 0; k < n_access; k++) begin
      cycle();
      check({tag, " access"}, {PSEL, PENABLE, rsp_valid, req_ready, PWRITE, PADDR, PWDATA},
            {1'b1, 1'b1, 1'b0, 1'b0, wr, addr, wdata});
      PREADY = (k == waits);
      PRDATA = (k == waits) ? rd : DW'($urandom);
    end
    cycle();
    PREADY = 1'b0;
    check({tag, " rsp"}, {PSEL, PENABLE, rsp_valid, rsp_err, req_ready, rsp_rdata},
          {1'b0, 1'b0, 1'b1, !ok, 1'b1, exp_rd});
    cycle();
    check({tag, " rsp_pulse"}, {rsp_valid, req_ready, PSEL, PADDR, PWDATA, PWRITE},
          {1'b0, 1'b1, 1'b0, addr, wdata, wr});
  endtask

  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_wdata[$];
  logic          q_write[$];

  initial begin
    logic [AW-1:0] ea[3];
    logic [DW-1:0] ew[3];
    logic          ewr[3];
    logic [DW-1:0] qrd;
    int            phase;
    int            idx;
    bit            exp_ready;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    cycle();
    cycle();
    check("reset_state", {req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
          64'd0);
    reset = 1'b1;
    cycle();
    check("ready_after_release", {63'd0, req_ready}, 64'd1);

    do_transfer("wr8", 1'b1, 20'd8, 16'd8, 0, 16'h5555);
    do_transfer("rd4", 1'b0, 20'd4, 16'h1234, 3, 16'h000A);
    do_transfer("rd12_timeout", 1'b0, 20'd12, 16'h0, 1000, 16'hBEEF);
    do_transfer("rd_limit", 1'b0, 20'h00ABC, 16'h0, TO - 1, 16'hC0DE);
    do_transfer("wr_limit", 1'b1, 20'h00123, 16'h7777, TO - 1, 16'hFFFF);

    // Back-to-back queue with PREADY tied high: one transfer every 3 cycles
    ea[0] = 20'd0;  ew[0] = 16'd3;  ewr[0] = 1'b1;
    ea[1] = 20'd4;  ew[1] = 16'd0;  ewr[1] = 1'b0;
    ea[2] = 20'd12; ew[2] = 16'd12; ewr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_addr.push_back(ea[i]); q_wdata.push_back(ew[i]); q_write.push_back(ewr[i]);
    end
    qrd = 16'h4321;
    PREADY = 1'b1; PRDATA = qrd;
    for (int t = 0; t < 12; t++) begin
      phase = t % 3;
      idx   = t / 3;
      exp_ready = (phase == 0) || (t >= 9);
      check("queue_ready", {63'd0, req_ready}, {63'd0, exp_ready});
      check("queue_ctrl", {62'd0, PSEL, PENABLE}, {62'd0, !exp_ready, (phase == 2) && (t < 9)});
      check("queue_rsp", {63'd0, rsp_valid}, {63'd0, (phase == 0) && (t >= 3) && (t <= 9)});
      if (phase == 1 && t < 9)
        check("queue_setup", {PWRITE, PADDR, PWDATA}, {ewr[idx], ea[idx], ew[idx]});
      if (phase == 0 && t >= 3 && t <= 9)
        check("queue_rdata", {rsp_err, rsp_rdata}, {1'b0, ewr[idx-1] ? 16'd0 : qrd});
      req_valid = (q_addr.size() > 0);
      if (q_addr.size() > 0) begin
        req_addr = q_addr[0]; req_wdata = q_wdata[0]; req_write = q_write[0];
      end
      @(posedge clk);
      if (req_valid && req_ready) begin
        void'(q_addr.pop_front()); void'(q_wdata.pop_front()); void'(q_write.pop_front());
      end
      @(negedge clk);
    end
    req_valid = 1'b0; PREADY = 1'b0;

    // Reset during ACCESS aborts silently
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00F0F; req_wdata = 16'h0;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    check("pre_abort_access", {62'd0, PSEL, PENABLE}, 64'd3);
    reset = 1'b0;
    cycle();
    check("abort", {req_ready, rsp_valid, PSEL, PENABLE, PADDR}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_abort", {62'd0, rsp_valid, req_ready}, 64'd1);
    end
    do_transfer("after_reset", 1'b0, 20'h00777, 16'h0, 2, 16'h9A9A);

    for (int i = 0; i < 8; i++) begin
      do_transfer("rand", 1'($urandom), AW'($urandom), DW'($urandom),
                  int'($urandom_range(0, 20)), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter AMBA_WORD, default 16: width of the data and request buses.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20: width of the address buses.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of ACCESS cycles waited for PREADY.
REQ-004 clk  input  1  single clock; all logic updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  1  a request is presented.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AMBA_ADDR_WIDTH  target address.
REQ-010 req_wdata  input  AMBA_WORD  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  AMBA_WORD  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  transfer timed out; qualified by rsp_valid.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 PADDR  output  AMBA_ADDR_WIDTH; PWDATA  output  AMBA_WORD  APB address and write data.
REQ-016 PRDATA  input  AMBA_WORD; PREADY  input  1  APB responder read data and ready.

Function
REQ-017 FSM SHALL have states IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-019 On acceptance in cycle N: req_addr, req_wdata and req_write SHALL be latched; the FSM moves to SETUP.
REQ-020 SETUP (cycle N+1): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; the next state is always ACCESS.
REQ-021 ACCESS (cycle N+2 onward): PSEL=1, PENABLE=1; PADDR, PWDATA and PWRITE SHALL remain stable until exit.
REQ-022 ACCESS with PREADY=1: the next cycle SHALL have rsp_valid=1, rsp_err=0, and rsp_rdata = PRDATA sampled on a read, 0 on a write; PSEL=0, PENABLE=0; state IDLE.
REQ-023 ACCESS with PREADY=0 SHALL increment the wait counter (width $clog2(TIMEOUT_CYCLES+1)); the counter SHALL clear on entry to SETUP.
REQ-024 If the counter reaches TIMEOUT_CYCLES-1 with PREADY=0: the next cycle SHALL have rsp_valid=1, rsp_err=1, rsp_rdata=0; PSEL=0, PENABLE=0; state IDLE.
REQ-025 If PREADY=1 arrives in the same cycle as the timeout limit, success SHALL win (rsp_err=0).
REQ-026 rsp_valid SHALL be a single-cycle pulse; there is no backpressure on the response.
REQ-027 req_* inputs SHALL be ignored outside IDLE; at most one transfer is outstanding.
REQ-028 In IDLE, PADDR and PWDATA SHALL hold their last values; PWRITE SHALL hold its last value.
REQ-029 Minimum transfer period: accept at N, response at N+3, next accept at N+3.

Reset
REQ-030 reset=0 at a clock edge: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid and rsp_err = 0; PADDR, PWDATA and rsp_rdata = 0; counter = 0; req_ready = 0 during reset and 1 from the first cycle after release.
REQ-031 Reset asserted mid-transfer SHALL abort it with no rsp_valid pulse.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default AMBA_WORD and AMBA_ADDR_WIDTH constants.
REQ-033 The timeout counter SHALL be a sub-module apb_wait_counter (inputs clear and enable, output expired).

Verification
REQ-034 Write addr=8, data=8, PREADY tied to 1 -> SETUP at N+1, ACCESS at N+2, rsp_valid with rsp_err=0 and rsp_rdata=0 at N+3.
REQ-035 Read addr=4, responder returns PRDATA=0x000A after 3 wait cycles -> PADDR stable for 5 cycles; rsp_rdata=0x000A, rsp_err=0.
REQ-036 Read addr=12, PREADY stuck at 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-037 req_valid held high with 3 queued requests (write 0/3, read 4, write 12/12) -> transfers issued in order, req_ready=1 only in IDLE, one rsp pulse each.
REQ-038 reset=0 during ACCESS -> PSEL=0 and PENABLE=0 at the next edge; no rsp_valid; a new request after release completes normally.
REQ-039 PREADY=1 exactly on the timeout-limit cycle -> rsp_err=0 and PRDATA returned.
